// File: rtl/sync_rca_pipe_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder/subtractor.
// The master drives operands and out_ready; the slave (the adder) drives in_ready and results.
interface sync_rca_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/sync_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: B result bits are resolved per stage, the
// carry ripples stage to stage, and the whole pipe stalls as one under backpressure.
module sync_rca_pipe #(
  parameter int WIDTH = 8,
  parameter int B     = 2
) (
  input  logic          clk,
  input  logic          rst,
  sync_rca_pipe_if.slave bus
);
  localparam int S = WIDTH / B;

  logic             en;
  logic [S-1:0]     vld_q;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  function automatic logic [B:0] slice_add(input logic [B-1:0] x,
                                           input logic [B-1:0] y,
                                           input logic         ci);
    return {1'b0, x} + {1'b0, y} + {{B{1'b0}}, ci};
  endfunction

  // The pipe only moves when the output slot is empty or being drained.
  assign en           = ~vld_q[S-1] | bus.out_ready;
  assign bus.in_ready = en;

  // Subtraction is a + ~b + 1, so sub forces the stage-0 carry-in high.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= bus.in_valid;
      for (int k = 1; k < S; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_st
    localparam int REM = WIDTH - (k + 1) * B;

    logic [B-1:0]         a_s;
    logic [B-1:0]         b_s;
    logic                 c_s;
    logic [B:0]           add_r;
    logic [(k+1)*B-1:0]   psum_d;
    logic [(k+1)*B-1:0]   s_q;
    logic                 c_q;

    // ---- stage k input: operand slice plus carry from the previous stage ----
    if (k == 0) begin : g_first
      assign a_s    = bus.a[B-1:0];
      assign b_s    = b_eff[B-1:0];
      assign c_s    = c0;
      assign psum_d = add_r[B-1:0];
    end else begin : g_next
      assign a_s    = g_st[k-1].g_up.a_q[B-1:0];
      assign b_s    = g_st[k-1].g_up.b_q[B-1:0];
      assign c_s    = g_st[k-1].c_q;
      assign psum_d = {add_r[B-1:0], g_st[k-1].s_q};
    end

    assign add_r = slice_add(a_s, b_s, c_s);

    // Upper operand bits travel alongside, shifted so the next slice sits at bit 0.
    if (REM > 0) begin : g_up
      logic [REM-1:0] a_d;
      logic [REM-1:0] b_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_src
        assign a_d = bus.a[WIDTH-1:B];
        assign b_d = b_eff[WIDTH-1:B];
      end else begin : g_src
        assign a_d = g_st[k-1].g_up.a_q[REM+B-1:B];
        assign b_d = g_st[k-1].g_up.b_q[REM+B-1:B];
      end

      always_ff @(posedge clk) begin
        if (en) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // ---- stage k register: partial sum and carry (last stage is the output) ----
    if (k < S - 1) begin : g_mid
      always_ff @(posedge clk) begin
        if (en) begin
          s_q <= psum_d;
          c_q <= add_r[B];
        end
      end
    end else begin : g_msb
      logic cmsb;
      logic ovf_q;

      // Carry into bit WIDTH-1 recovered from that bit's sum and operands.
      assign cmsb = add_r[B-1] ^ a_s[B-1] ^ b_s[B-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q   <= '0;
          c_q   <= 1'b0;
          ovf_q <= 1'b0;
        end else if (en) begin
          s_q   <= psum_d;
          c_q   <= add_r[B];
          ovf_q <= cmsb ^ add_r[B];
        end
      end
    end
  end

  assign bus.out_valid = vld_q[S-1];
  assign bus.sum       = g_st[S-1].s_q;
  assign bus.cout      = g_st[S-1].c_q;
  assign bus.ovf       = g_st[S-1].g_msb.ovf_q;
endmodule

// File: tb/tb_sync_rca_pipe.sv
// Scoreboard bench for sync_rca_pipe (WIDTH=8, B=2): drivers push expected results on
// acceptance, a separate monitor pops and compares on every output transfer.
module tb_sync_rca_pipe;
  localparam int WIDTH = 8;
  localparam int B     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_rca_pipe_if #(.WIDTH(WIDTH)) bus ();
  sync_rca_pipe #(.WIDTH(WIDTH), .B(B)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];   // {ovf, cout, sum}

  logic [7:0] ra, rb;
  logic       rc, rs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed overflow judged from the signed value range, carry from 9-bit sum.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci, input logic sb);
    logic [7:0] be;
    int c, r, sr;
    logic o;
    be = sb ? ~b : b;
    c  = sb ? 1 : int'(ci);
    r  = int'(a) + int'(be) + c;
    sr = int'($signed(a)) + int'($signed(be)) + c;
    o  = (sr > 127) || (sr < -128);
    return {o, r[8], r[7:0]};
  endfunction

  // Drive one beat starting just after a posedge; return just after its accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic sb, input logic [9:0] e);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.cin = ci; bus.sub = sb;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'd0, bus.in_ready}, 1);
    if (bus.in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("beat_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        check("result", {22'd0, bus.ovf, bus.cout, bus.sum}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_sum", {24'd0, bus.sum}, 0);
    check("rst_cout", {31'd0, bus.cout}, 0);
    check("rst_ovf", {31'd0, bus.ovf}, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    @(posedge clk); #1;

    // Single beat with latency probe: visible only after the fourth edge.
    send(8'h35, 8'h1A, 1'b0, 1'b0, {1'b0, 1'b0, 8'h4F});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("latency_early", {31'd0, bus.out_valid}, 0);
    end
    @(negedge clk);
    check("latency_arrive", {31'd0, bus.out_valid}, 1);
    drain();

    // Carry, overflow and subtract corners, back-to-back.
    send(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    send(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    send(8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0});
    send(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    send(8'h05, 8'h03, 1'b1, 1'b1, {1'b0, 1'b1, 8'h02});
    send(8'h01, 8'h01, 1'b1, 1'b0, {1'b0, 1'b0, 8'h03});
    drain();

    // 20 back-to-back random beats with a four-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = 8'($urandom); rb = 8'($urandom);
          rc = 1'($urandom); rs = 1'($urandom);
          send(ra, rb, rc, rs, ref_add(ra, rb, rc, rs));
        end
      end
      begin
        for (int c = 0; c < 12; c++) begin
          bus.out_ready = !(c >= 6 && c <= 9);
          @(negedge clk);
          if (c >= 6 && c <= 9) check("in_ready_stall", {31'd0, bus.in_ready}, 0);
          if (c == 10) check("in_ready_resume", {31'd0, bus.in_ready}, 1);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: in-flight beats vanish and nothing stale emerges.
    for (int i = 0; i < 5; i++) begin
      send(8'(i + 1), 8'h10, 1'b0, 1'b0, ref_add(8'(i + 1), 8'h10, 1'b0, 1'b0));
    end
    check("pre_rst_valid", {31'd0, bus.out_valid}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 0);
    check("mid_rst_sum", {24'd0, bus.sum}, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale", {31'd0, bus.out_valid}, 0);
    end
    @(posedge clk); #1;

    // Alternating bubbles: 0+0+cin gives 0x01 on every other output cycle.
    fork
      begin
        for (int j = 0; j < 6; j++) begin
          send(8'h00, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h01});
          @(posedge clk); #1;
        end
      end
      begin
        for (int c = 0; c < 16; c++) begin
          @(negedge clk);
          check("alt_valid", {31'd0, bus.out_valid},
                {31'd0, (c >= 4) && ((c - 4) % 2 == 0) && ((c - 4) / 2 < 6)});
        end
      end
    join
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
